sdram_core_bram: RTL

- Responder end of sdram_core_if: accepts burst read/write requests on the core side of the interface and services them from on-chip block RAM.
- Stands in for the SDRAM core behind sdram_arb, or behind any single client.
- Used for FPGA bring-up without external SDRAM, and as a cycle-predictable core model in arbiter and client benches.
- Read and write latency are programmable to mimic the real core.

---
 rtl/sdram_core_bram_if.sv | 27 ++
 rtl/sdram_core_bram.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sdram_core_bram_if.sv
// Core-side burst interface between an SDRAM manager (arbiter or client) and a core.
// The manager owns the request fields; the core owns the response fields.
interface sdram_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic                  rd;
  logic [DATA_W/8-1:0]   wr;
  logic [LEN_W-1:0]      len;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     write_data;
  logic                  accept;
  logic                  ack;
  logic                  error;
  logic [DATA_W-1:0]     read_data;

  modport sub (
    input  rd, wr, len, addr, write_data,
    output accept, ack, error, read_data
  );

  modport mgr (
    output rd, wr, len, addr, write_data,
    input  accept, ack, error, read_data
  );
endinterface

// File: rtl/sdram_core_bram.sv
// Block-RAM stand-in for the SDRAM core: services burst reads/writes on sdram_core_if
// with programmable first-beat latency, one beat per cycle once the burst starts.
module sdram_core_bram #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 8,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 1
) (
  input  logic      clk,
  input  logic      rst,
  sdram_core_if.sub core_if
);
  localparam int BE_W    = DATA_W / 8;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ERR} state_t;

  state_t                  state, state_nxt;
  logic                    op_rd;
  logic [BE_W-1:0]         mask;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        beat;
  logic [DEPTH_LOG2-1:0]   cur_addr;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [LAT_W-1:0]        lat_cnt;
  logic [DATA_W-1:0]       rd_q;
  logic [ADDR_W:0]         end_addr;
  logic                    req, conflict, overflow, last;
  logic                    accept, ack, error;
  logic [DATA_W-1:0]       read_data;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req      = core_if.rd | (|core_if.wr);
  assign conflict = core_if.rd & (|core_if.wr);
  // One extra bit so a burst running past the top of memory cannot wrap to look legal.
  assign end_addr = {1'b0, core_if.addr} + (ADDR_W + 1)'(core_if.len);
  assign overflow = end_addr > (ADDR_W + 1)'(DEPTH - 1);
  assign last     = (beat == len_q);

  // Reads are issued one cycle ahead of the beat so rd_q is registered in time.
  assign rd_idx = (state == S_XFER) ? cur_addr + DEPTH_LOG2'(1) : cur_addr;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned; a missing default infers a latch.
    state_nxt = state;
    accept    = 1'b0;
    ack       = 1'b0;
    error     = 1'b0;
    read_data = '0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (conflict || overflow)           state_nxt = S_ERR;
          else if (!core_if.rd && WR_LAT == 1) state_nxt = S_XFER;
          else                                 state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = S_XFER;
      end
      S_XFER: begin
        accept    = 1'b1;
        read_data = op_rd ? rd_q : '0;
        if (last) begin
          ack       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        ack       = 1'b1;
        error     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign core_if.accept    = accept;
  assign core_if.ack       = ack;
  assign core_if.error     = error;
  assign core_if.read_data = read_data;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_rd    <= 1'b0;
      mask     <= '0;
      len_q    <= '0;
      beat     <= '0;
      cur_addr <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_rd    <= core_if.rd;
            mask     <= core_if.wr;
            len_q    <= core_if.len;
            cur_addr <= core_if.addr[DEPTH_LOG2-1:0];
            beat     <= '0;
            lat_cnt  <= core_if.rd ? LAT_W'(RD_LAT - 1) : LAT_W'(WR_LAT - 1);
          end
        end
        S_WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
        S_XFER: begin
          beat     <= beat + LEN_W'(1);
          cur_addr <= cur_addr + DEPTH_LOG2'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the memory array and its output register are deliberately not reset so the
  // block maps onto BRAM; only the write enable honours rst, so an aborted burst stops.
  always_ff @(posedge clk) begin
    rd_q <= mem[rd_idx];
    if (!rst && state == S_XFER && !op_rd) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mask[i]) mem[cur_addr][8*i +: 8] <= core_if.write_data[8*i +: 8];
      end
    end
  end
endmodule
